// File: rtl/murax_board_io.sv
// murax_board_io: debounced switches onto the GPIO read bus, GPIO write bus onto LEDs
// in static, blink or PWM-dim mode.
module murax_board_io #(
  parameter int NUM_SW = 16,
  parameter int NUM_LED = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLINK_DIV = 8,
  parameter int PWM_BITS = 4
) (
  input  logic                io_mainClk,
  input  logic                io_reset,
  input  logic [NUM_SW-1:0]   sw,
  output logic [31:0]         io_gpioA_read,
  output logic                io_sw_changed,
  input  logic [31:0]         io_gpioA_write,
  input  logic [31:0]         io_gpioA_writeEnable,
  input  logic [1:0]          io_led_mode,
  input  logic [PWM_BITS-1:0] io_led_duty,
  output logic [NUM_LED-1:0]  io_led
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [NUM_SW-1:0] sync1, sync2, stable, upd;
  logic [CW-1:0] cnt [NUM_SW];
  logic [BW-1:0] blink_cnt;
  logic phase, blink_wrap, pwm_on;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_LED-1:0] base, led_next;
  logic unused_bits;
  always_ff @(posedge io_mainClk) begin
    if (io_reset) begin
      sync1 <= '0;
      sync2 <= '0;
      stable <= '0;
      io_sw_changed <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      stable <= stable ^ upd;
      io_sw_changed <= |upd;
    end
  end
  // upd fires on the DEBOUNCE_CYCLES-th consecutive sample that disagrees with stable
  for (genvar i = 0; i < NUM_SW; i++) begin : g_db
    assign upd[i] = (sync2[i] != stable[i]) && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge io_mainClk) begin
      if (io_reset || sync2[i] == stable[i] || upd[i]) cnt[i] <= '0;
      else cnt[i] <= cnt[i] + 1'b1;
    end
  end
  assign io_gpioA_read = 32'(stable);
  assign base = io_gpioA_write[NUM_LED-1:0] & io_gpioA_writeEnable[NUM_LED-1:0];
  assign unused_bits = ^{io_gpioA_write, io_gpioA_writeEnable};
  assign blink_wrap = blink_cnt == BW'(BLINK_DIV - 1);
  assign pwm_on = pwm_cnt < io_led_duty;
  always_comb led_next = io_led_mode == 2'b01 ? base & {NUM_LED{phase}} :
                         io_led_mode == 2'b10 ? base & {NUM_LED{pwm_on}} : base;
  always_ff @(posedge io_mainClk) begin
    if (io_reset) begin
      blink_cnt <= '0;
      phase <= 1'b0;
      pwm_cnt <= '0;
      io_led <= '0;
    end else begin
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      phase <= phase ^ blink_wrap;
      pwm_cnt <= pwm_cnt + 1'b1;
      io_led <= led_next;
    end
  end
endmodule
